// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges never-stalled pipeline W-stage writes with
// late results queued in a small FIFO. Optional trace output under RF_WB_TRACE_EN.
module rf_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_wr,
    input  logic [4:0]  p_a3,
    input  logic [31:0] p_wd,
    input  logic [31:0] p_pc,
    input  logic [31:0] p_instr,
    input  logic        l_valid,
    output logic        l_ready,
    input  logic [4:0]  l_a3,
    input  logic [31:0] l_wd,
    input  logic [31:0] l_pc,
    input  logic [31:0] l_instr,
    output logic        RF_wr,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic [31:0] busy,
    output logic        conflict
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    // Late-result queue storage; live marks an entry that will still be written.
    logic [4:0]       r_q_a3    [DEPTH];
    logic [31:0]      r_q_wd    [DEPTH];
    logic [31:0]      r_q_pc    [DEPTH];
    logic [31:0]      r_q_instr [DEPTH];
    logic [DEPTH-1:0] r_q_live;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic             r_rf_wr;
    logic [4:0]       r_a3;
    logic [31:0]      r_wd;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic             r_conflict;

    logic             w_push;
    logic             w_pop;
    logic             w_p_issue;
    logic             w_l_issue;
    logic             w_nonempty;
    logic [DEPTH-1:0] w_kill;
    logic [31:0]      w_busy;
    logic             w_nxt_wr;
    logic [4:0]       w_nxt_a3;
    logic [31:0]      w_nxt_wd;
    logic [31:0]      w_nxt_pc;
    logic [31:0]      w_nxt_instr;

    // Late port handshake: an entry transfers on a rising edge where l_valid && l_ready;
    // l_ready depends only on the stored count, never on l_valid or the pop decision.
    assign l_ready    = (r_count < FULL_CNT);
    assign w_push     = l_valid && l_ready;
    assign w_nonempty = (r_count != '0);

    // A pipeline write to $0 is a no-op and leaves the slot to the FIFO.
    assign w_p_issue  = p_wr && (p_a3 != 5'd0);
    assign w_pop      = !w_p_issue && w_nonempty;
    assign w_l_issue  = w_pop && r_q_live[r_rd_ptr];

    always_comb begin
        w_kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_kill[i] = w_p_issue && r_q_live[i] && (r_q_a3[i] == p_a3);
        end
    end

    always_comb begin
        w_busy = '0;
        for (int r = 1; r < 32; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_q_live[i] && (r_q_a3[i] == 5'(r))) begin
                    w_busy[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_nxt_wr    = 1'b0;
        w_nxt_a3    = r_a3;
        w_nxt_wd    = r_wd;
        w_nxt_pc    = r_pc;
        w_nxt_instr = r_instr;
        if (w_p_issue) begin
            w_nxt_wr    = 1'b1;
            w_nxt_a3    = p_a3;
            w_nxt_wd    = p_wd;
            w_nxt_pc    = p_pc;
            w_nxt_instr = p_instr;
        end else if (w_l_issue) begin
            w_nxt_wr    = 1'b1;
            w_nxt_a3    = r_q_a3[r_rd_ptr];
            w_nxt_wd    = r_q_wd[r_rd_ptr];
            w_nxt_pc    = r_q_pc[r_rd_ptr];
            w_nxt_instr = r_q_instr[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_a3[r_wr_ptr]    <= l_a3;
            r_q_wd[r_wr_ptr]    <= l_wd;
            r_q_pc[r_wr_ptr]    <= l_pc;
            r_q_instr[r_wr_ptr] <= l_instr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q_live <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // The slot being pushed is never occupied, so a same-register kill cannot touch it.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == PTR_W'(i))) begin
                    r_q_live[i] <= (l_a3 != 5'd0);
                end else if (w_kill[i] || (w_pop && (r_rd_ptr == PTR_W'(i)))) begin
                    r_q_live[i] <= 1'b0;
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rf_wr    <= 1'b0;
            r_a3       <= '0;
            r_wd       <= '0;
            r_pc       <= '0;
            r_instr    <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_rf_wr    <= w_nxt_wr;
            r_a3       <= w_nxt_a3;
            r_wd       <= w_nxt_wd;
            r_pc       <= w_nxt_pc;
            r_instr    <= w_nxt_instr;
            r_conflict <= r_conflict | (|w_kill);
        end
    end

`ifdef RF_WB_TRACE_EN
    always @(posedge clk) begin
        if (reset && w_nxt_wr) begin
            $display("%h @%h: $%d <= %h", w_nxt_instr, w_nxt_pc, w_nxt_a3, w_nxt_wd);
        end
        if (reset && (|w_kill)) begin
            $display("WB CONFLICT $%d", p_a3);
        end
    end
`else
    // Trace disabled: the write port behaves identically, only the log is absent.
`endif

    assign RF_wr    = r_rf_wr;
    assign A3       = r_a3;
    assign WD       = r_wd;
    assign PC       = r_pc;
    assign Instr    = r_instr;
    assign busy     = w_busy;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: per-cycle vector table plus hand-written
// sequences for FIFO fill/wrap, register conflicts and mid-traffic reset.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_wr;
    logic [4:0]  p_a3;
    logic [31:0] p_wd;
    logic [31:0] p_pc;
    logic [31:0] p_instr;
    logic        l_valid;
    logic        l_ready;
    logic [4:0]  l_a3;
    logic [31:0] l_wd;
    logic [31:0] l_pc;
    logic [31:0] l_instr;
    logic        RF_wr;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic [31:0] busy;
    logic        conflict;

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q[$];

    rf_wb_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .p_wr(p_wr), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc), .p_instr(p_instr),
        .l_valid(l_valid), .l_ready(l_ready), .l_a3(l_a3), .l_wd(l_wd),
        .l_pc(l_pc), .l_instr(l_instr),
        .RF_wr(RF_wr), .A3(A3), .WD(WD), .PC(PC), .Instr(Instr),
        .busy(busy), .conflict(conflict)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Trace tags are derived from the data so every write carries a unique PC/Instr.
    function automatic logic [31:0] pc_of(input logic [31:0] d);
        return d ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] ins_of(input logic [31:0] d);
        return {d[15:0], d[31:16]} ^ 32'h0000_3C3C;
    endfunction

    // driver tasks
    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        p_wr    = pw;
        p_a3    = pa;
        p_wd    = pd;
        p_pc    = pc_of(pd);
        p_instr = ins_of(pd);
        l_valid = lv;
        l_a3    = la;
        l_wd    = ld;
        l_pc    = pc_of(ld);
        l_instr = ins_of(ld);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_write(input string name, input logic [4:0] ea3, input logic [31:0] ewd);
        chk({name, ".wr"},    32'(RF_wr), 32'd1);
        chk({name, ".a3"},    32'(A3),    32'(ea3));
        chk({name, ".wd"},    WD,         ewd);
        chk({name, ".pc"},    PC,         pc_of(ewd));
        chk({name, ".instr"}, Instr,      ins_of(ewd));
    endtask

    // scoreboard: compare a late write against the oldest expected entry
    task automatic chk_late(input string name);
        logic [36:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got a3=%0d with empty expected queue", name, A3);
        end else begin
            e = exp_q.pop_front();
            chk_write(name, e[36:32], e[31:0]);
        end
    endtask

    typedef struct {
        logic        p_wr;
        logic [4:0]  p_a3;
        logic [31:0] p_wd;
        logic        l_valid;
        logic [4:0]  l_a3;
        logic [31:0] l_wd;
        logic        e_wr;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
        logic        e_ready;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1'b1, 5'd5, 32'h1234,     1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h1234,     32'h0,   1'b1};
        vecs[1]  = '{1'b1, 5'd0, 32'h9999,     1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'h1234,     32'h0,   1'b1};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'h1234,     32'h0,   1'b1};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 32'hDEAD0001, 1'b0, 5'd5, 32'h1234,     32'h100, 1'b1};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 32'hDEAD0001, 32'h0,   1'b1};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h9009,     1'b0, 5'd8, 32'hDEAD0001, 32'h200, 1'b1};
        vecs[6]  = '{1'b1, 5'd3, 32'h303,      1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h303,      32'h200, 1'b1};
        vecs[7]  = '{1'b1, 5'd4, 32'h404,      1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h404,      32'h200, 1'b1};
        vecs[8]  = '{1'b1, 5'd5, 32'h505,      1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h505,      32'h200, 1'b1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h9009,     32'h0,   1'b1};
        vecs[10] = '{1'b1, 5'd0, 32'hAAAA,     1'b1, 5'd0, 32'hBAD,      1'b0, 5'd9, 32'h9009,     32'h0,   1'b1};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 32'h9009,     32'h0,   1'b1};
        vecs[12] = '{1'b1, 5'd0, 32'hBBBB,     1'b1, 5'd6, 32'h606,      1'b0, 5'd9, 32'h9009,     32'h40,  1'b1};
        vecs[13] = '{1'b1, 5'd0, 32'hCCCC,     1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 32'h606,      32'h0,   1'b1};

        // power-on reset
        reset = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.wr", 32'(RF_wr), 32'd0);
        chk("rst.a3", 32'(A3), 32'd0);
        chk("rst.wd", WD, 32'd0);
        chk("rst.busy", busy, 32'd0);
        chk("rst.ready", 32'(l_ready), 32'd1);
        chk("rst.conflict", 32'(conflict), 32'd0);
        reset = 1'b1;

        // table: pipeline-only, late latency, ordering behind pipeline, dead entries, wrap
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].p_wr, vecs[i].p_a3, vecs[i].p_wd,
                  vecs[i].l_valid, vecs[i].l_a3, vecs[i].l_wd);
            tick();
            chk($sformatf("v%0d.wr", i),       32'(RF_wr),    32'(vecs[i].e_wr));
            chk($sformatf("v%0d.a3", i),       32'(A3),       32'(vecs[i].e_a3));
            chk($sformatf("v%0d.wd", i),       WD,            vecs[i].e_wd);
            chk($sformatf("v%0d.pc", i),       PC,            pc_of(vecs[i].e_wd));
            chk($sformatf("v%0d.instr", i),    Instr,         ins_of(vecs[i].e_wd));
            chk($sformatf("v%0d.busy", i),     busy,          vecs[i].e_busy);
            chk($sformatf("v%0d.ready", i),    32'(l_ready),  32'(vecs[i].e_ready));
            chk($sformatf("v%0d.conflict", i), 32'(conflict), 32'd0);
        end

        // fill four entries while the pipeline owns the port
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(20 + k), 32'h2000 + 32'(k), 1'b1, 5'(10 + k), 32'hE000 + 32'(k));
            exp_q.push_back({5'(10 + k), 32'hE000 + 32'(k)});
            tick();
            chk_write($sformatf("fill%0d", k), 5'(20 + k), 32'h2000 + 32'(k));
            chk($sformatf("fill%0d.ready", k), 32'(l_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        chk("full.busy", busy, 32'h0000_3C00);

        // fifth offer is refused while full
        drive(1'b1, 5'd24, 32'h2004, 1'b1, 5'd14, 32'hE004);
        tick();
        chk_write("held", 5'd24, 32'h2004);
        chk("held.ready", 32'(l_ready), 32'd0);

        // drain: the freed slot opens next cycle, then push+pop share cycles
        idle();
        tick();
        chk_late("drain0");
        chk("drain0.ready", 32'(l_ready), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'hE004);
        exp_q.push_back({5'd14, 32'hE004});
        tick();
        chk_late("drain1");
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'hE005);
        exp_q.push_back({5'd15, 32'hE005});
        tick();
        chk_late("drain2");
        chk("drain2.busy", busy, 32'h0000_E000);
        idle();
        for (int k = 3; k < 6; k++) begin
            tick();
            chk_late($sformatf("drain%0d", k));
        end
        chk("drained.busy", busy, 32'd0);
        chk("drained.q", 32'(exp_q.size()), 32'd0);
        tick();
        chk("drained.wr", 32'(RF_wr), 32'd0);

        // conflict: pipeline write to a pending register kills the older entry only
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h7001);
        tick();
        chk_write("cfA", 5'd1, 32'h11);
        chk("cfA.busy", busy, 32'h80);
        chk("cfA.conflict", 32'(conflict), 32'd0);
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h7002);
        tick();
        chk_write("cfB", 5'd7, 32'h77);
        chk("cfB.conflict", 32'(conflict), 32'd1);
        chk("cfB.busy", busy, 32'h80);
        idle();
        tick();
        chk("cfC.wr", 32'(RF_wr), 32'd0);
        chk("cfC.wd", WD, 32'h77);
        chk("cfC.busy", busy, 32'h80);
        tick();
        chk_write("cfD", 5'd7, 32'h7002);
        chk("cfD.busy", busy, 32'd0);
        chk("cfD.conflict", 32'(conflict), 32'd1);
        tick();
        chk("cfE.wr", 32'(RF_wr), 32'd0);
        chk("cfE.conflict", 32'(conflict), 32'd1);

        // asynchronous reset with entries queued
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd17, 32'h1700);
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd18, 32'h1800);
        tick();
        chk("pre_rst.busy", busy, 32'h0006_0000);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.wr", 32'(RF_wr), 32'd0);
        chk("arst.a3", 32'(A3), 32'd0);
        chk("arst.wd", WD, 32'd0);
        chk("arst.pc", PC, 32'd0);
        chk("arst.instr", Instr, 32'd0);
        chk("arst.busy", busy, 32'd0);
        chk("arst.conflict", 32'(conflict), 32'd0);
        chk("arst.ready", 32'(l_ready), 32'd1);
        idle();
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst%0d.wr", k), 32'(RF_wr), 32'd0);
            chk($sformatf("post_rst%0d.busy", k), busy, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Writer-side front end for the register file's single write port (A3/WD/RF_wr plus PC/Instr trace tags).
- Merges two result sources:
  - in-order pipeline W-stage writes, which are never stalled;
  - late results from multi-cycle units (mult/div, slow loads), held in a small FIFO.
- Outputs are registered and drive the RF write port directly.
- Exports a per-register busy vector so the hazard unit stalls readers of pending registers.

Parameters:
- DEPTH, 4, late-result FIFO entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- p_wr  in  1  pipeline W-stage write request this cycle.
- p_a3  in  5  pipeline destination register.
- p_wd  in  32  pipeline write data.
- p_pc  in  32  pipeline instruction PC (trace tag).
- p_instr  in  32  pipeline instruction word (trace tag).
- l_valid  in  1  late-result offer.
- l_ready  out  1  FIFO can accept; high when count < DEPTH.
- l_a3  in  5  late destination register.
- l_wd  in  32  late write data.
- l_pc  in  32  late PC tag.
- l_instr  in  32  late instruction tag.
- RF_wr  out  1  registered write enable to the RF.
- A3  out  5  registered write address.
- WD  out  32  registered write data.
- PC  out  32  registered PC tag.
- Instr  out  32  registered instruction tag.
- busy  out  32  bit i = 1 while a live FIFO entry targets $i; bit 0 is always 0.
- conflict  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - RF_wr=0, A3=0, WD=0, PC=0, Instr=0, busy=0, conflict=0.
  - FIFO emptied (rd/wr pointers and count = 0); all entry live bits cleared.
  - Reset mid-drain discards every queued entry.
- Accept: a late entry is pushed on a cycle with l_valid && l_ready.
  - Entries with l_a3==0 are accepted but stored dead: never written, never mark busy.
- Issue priority, evaluated each cycle:
  1. If p_wr && p_a3!=0: pipeline write goes out next edge (RF_wr=1, A3/WD/PC/Instr = p_*). FIFO does not pop.
  2. Else if the FIFO head is live: head goes out next edge and pops.
  3. Else if the FIFO head is dead: head pops silently with RF_wr=0.
  4. Else: RF_wr=0. A3/WD/PC/Instr hold their last values.
- p_wr with p_a3==0 counts as idle. It is not forwarded and the FIFO may drain that cycle.
- Latency:
  - Pipeline: 1 cycle from input to RF port.
  - Late: at least 2 cycles from push to RF port (push edge, then issue edge).
  - An entry pushed into an empty FIFO on an idle cycle reaches RF_wr exactly 2 edges later.
- Full/simultaneous:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - When full, l_ready=0 and a pop frees the slot from the next cycle. There is no same-cycle pass-through.
- Pointers wrap modulo DEPTH. count is PTR_W+1 bits.
- Busy vector is recomputed from the live entries after each edge. It includes an entry being pushed (visible the next cycle) and excludes the entry being popped.
- Conflict:
  - Condition: a pipeline write to $x (x!=0) occurs while a live FIFO entry targets $x.
  - The pipeline write wins.
  - Every matching entry is marked dead in that edge.
  - conflict is set to 1 and stays set until reset.
  - An entry being pushed on the same cycle with the same register is not killed; it is younger.
- FIFO order is strict; live entries issue in push order.

Optional Feature:
- Macro: RF_WB_TRACE_EN.
- Defined:
  - On every edge where RF_wr becomes 1, $display "%h @%h: $%d <= %h" with Instr, PC, A3, WD of the issued write.
  - On conflict set, also $display "WB CONFLICT $%d".
- Undefined: no simulation output; logic is identical.

Test Plan:
1. Reset with reset=0 mid-traffic, then release -> all outputs 0, l_ready=1, busy=0.
2. Pipeline-only, p_wr=1, p_a3=5, p_wd=0x1234 -> next edge RF_wr=1, A3=5, WD=0x00001234. Repeat with p_a3=0 -> RF_wr=0.
3. Push late {a3=8, wd=0xDEAD0001} while idle -> busy[8]=1 after the push edge; RF_wr=1, A3=8 two edges after push; busy[8]=0 after the pop.
4. Push late {a3=9}, then hold p_wr=1 to $3,$4,$5 for 3 cycles -> late write appears on the 4th cycle, after the pipeline writes, in order.
5. Fill 4 entries {a3=10..13} with the pipeline busy -> l_ready=0; a 5th push is held off. Then idle -> entries issue 10,11,12,13; the pointer wrap is exercised by 2 more pushes.
6. Queue late {a3=7}, then pipeline write $7=0x77 -> RF gets 0x77, the late entry is never written, busy[7]=0, conflict=1 until reset.
